ram_lsu: RTL and testbench
==========================

Name: ram_lsu

Overview:
Load/store initiator for the byte-lane data RAM, the requesting end of its write-port / read-port interface. Accepts one core memory request at a time: byte, half or word, signed or unsigned, any alignment. Generates byte-lane write enables, lane-shifted write data and read strobes. Realigns and extends the returned read data. Misaligned accesses that cross a word boundary are split into two RAM accesses.

Parameters:
ADDR_WIDTH, 32, width of core and RAM addresses (RV32_ADDR_WIDTH)
DATA_WIDTH, 32, data width; fixed at 4 byte lanes
RAM_ADDR_WIDTH, 12, byte-address bits decoded by the RAM; higher bits ignored

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word
req_unsigned_i  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr_i  in  ADDR_WIDTH  byte address
req_wdata_i  in  DATA_WIDTH  store data, right-justified
rsp_valid_o  out  1  one-cycle completion pulse (loads and stores)
rsp_rdata_o  out  DATA_WIDTH  extended load data; valid with rsp_valid_o
ram_wr_en_o  out  4  byte-lane write enables
ram_wr_addr_o  out  ADDR_WIDTH  word-aligned write address
ram_wr_data_o  out  DATA_WIDTH  lane-positioned write data
ram_rd_en_o  out  1  read strobe
ram_rd_addr_o  out  ADDR_WIDTH  word-aligned read address
ram_rd_data_i  in  DATA_WIDTH  RAM read data, 1-cycle latency after address

Behaviour:
- All RAM-side outputs, rsp_valid_o and rsp_rdata_o are registered. Reset value of every output is 0, except req_ready_o = 1 once in IDLE.
- req_ready_o = (state == IDLE). Request fields are captured at the accept edge; inputs are don't-care afterwards.
- Offset = addr[1:0]. 8-bit lane mask m = (size mask 1/3/F) << offset.
- Split when m[7:4] != 0: half at offset 3, or word at offset 1-3. Half at offset 1 is not split.
- Low word address = {addr[ADDR_WIDTH-1:2], 2'b00}. High word = low + 4, wrapping modulo 2^RAM_ADDR_WIDTH within the decoded field. Upper bits are passed through unchanged.
- Store data: 64-bit {0, wdata} << 8*offset; low half goes to the first access, high half to the second.
- Load data: 64-bit {hi, lo} >> 8*offset, truncated to size, then sign- or zero-extended.
- States: IDLE, ST_HI, LD_A, LD_B, LD_C. Cycle numbers below count from the accept edge; C1 is the first cycle after it.
- Aligned store: C1 ram_wr_en = m[3:0] and rsp_valid_o = 1; state IDLE in C1.
- Split store: C1 writes low word with m[3:0] (state ST_HI). C2 writes high word with m[7:4], rsp_valid_o = 1, then IDLE.
- Aligned load: C1 LD_A, rd_en = 1, low address. C2 LD_C, data present and captured. C3 IDLE, rsp_valid_o = 1 with rsp_rdata_o.
- Split load: C1 LD_A reads low. C2 LD_B reads high and captures low. C3 LD_C captures high. C4 rsp_valid_o = 1.
- ram_wr_en_o and ram_rd_en_o are 0 in every cycle not listed above. Write and read are never issued in the same cycle.
- Back-to-back: in the rsp cycle the state is IDLE, so a new request may be accepted in that same cycle. Throughput is 1 store per cycle for aligned stores.
- rsp_rdata_o holds its last value between responses. It is 0 on a store response.
- Reset mid-operation: asynchronous return to IDLE; all outputs cleared immediately. The in-flight transaction is dropped: no rsp, and no further RAM strobes.

Decomposition:
- Shared defines: LSU_SIZE_B/H/W encodings; RAM_ADDR_WIDTH; RD_ENABLE; lane count.
- State encodings stay local.
- One combinational sub-module, lsu_align: lane-mask generation, store shift, load extract/extend. The FSM and registers stay in ram_lsu.

Test Plan:
1. Store word 0xDEADBEEF @0x10 -> C1: wr_en 1111, wr_addr 0x10, wr_data 0xDEADBEEF, rsp_valid 1; req_ready 1 in C1.
2. Store byte 0xA5 @0x13 -> wr_en 1000, wr_data[31:24] = A5. Then load byte signed @0x13 -> C3 rsp_rdata 0xFFFFFFA5; unsigned -> 0x000000A5.
3. Store word 0x11223344 @0x22 -> C1 wr_en 1100 @0x20 with lanes 2,3 = 44,33; C2 wr_en 0011 @0x24 with lanes 0,1 = 22,11. Load word @0x22 -> rd addrs 0x20 (C1), 0x24 (C2); C4 rdata 0x11223344.
4. Bytes [7] = 0x80, [8] = 0x90. Load half signed @0x07 -> split, rdata 0xFFFF9080; unsigned -> 0x00009080.
5. Load word @0xFFE (RAM_ADDR_WIDTH 12) -> second rd addr low 12 bits = 0x000; data combined correctly.
6. rst pulse in C2 of split load -> all outputs 0 that cycle, no rsp_valid, no further rd_en. After release, a new request accepted in its rsp cycle completes normally.

Source files
------------

// File: rtl/ram_lsu_pkg.sv
// Shared encodings and helpers for the load/store unit and its byte-lane RAM port.
package ram_lsu_pkg;

    localparam int unsigned LANES                  = 4;
    localparam int unsigned WORD_WIDTH             = LANES * 8;
    localparam int unsigned DEFAULT_RAM_ADDR_WIDTH = 12;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    localparam logic RD_ENABLE = 1'b1;

    // Reserved size 2'b11 behaves as a word.
    function automatic logic [LANES-1:0] size_mask(input logic [1:0] size);
        unique case (size)
            LSU_SIZE_B: size_mask = 4'b0001;
            LSU_SIZE_H: size_mask = 4'b0011;
            default:    size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ram_lsu_if.sv
// Core request/response and RAM write/read port signals of the load/store unit.
interface ram_lsu_if
    import ram_lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  rsp_valid_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic [LANES-1:0]      ram_wr_en_o;
    logic [ADDR_WIDTH-1:0] ram_wr_addr_o;
    logic [DATA_WIDTH-1:0] ram_wr_data_o;
    logic                  ram_rd_en_o;
    logic [ADDR_WIDTH-1:0] ram_rd_addr_o;
    logic [DATA_WIDTH-1:0] ram_rd_data_i;

    // master: the load/store unit itself
    modport master (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  ram_rd_data_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o,
        output ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_en_o, ram_rd_addr_o
    );

    // slave: core plus RAM environment
    modport slave (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output ram_rd_data_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o,
        input  ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_en_o, ram_rd_addr_o
    );

endinterface

// File: rtl/lsu_align.sv
// Lane-mask generation, store data lane shift and load extract/extend.
module lsu_align
    import ram_lsu_pkg::*;
(
    input  logic [1:0]            size_i,
    input  logic                  zero_ext_i,
    input  logic [1:0]            offset_i,
    input  logic [WORD_WIDTH-1:0] st_data_i,
    input  logic [WORD_WIDTH-1:0] ld_lo_i,
    input  logic [WORD_WIDTH-1:0] ld_hi_i,
    output logic [2*LANES-1:0]    lane_mask_o,
    output logic [WORD_WIDTH-1:0] st_lo_o,
    output logic [WORD_WIDTH-1:0] st_hi_o,
    output logic [WORD_WIDTH-1:0] ld_data_o
);

    logic [4:0]            shamt;
    logic [WORD_WIDTH-1:0] ld_word;
    logic                  sign;

    assign shamt       = {offset_i, 3'b000};
    assign lane_mask_o = {4'b0000, size_mask(size_i)} << offset_i;
    assign {st_hi_o, st_lo_o} = {{WORD_WIDTH{1'b0}}, st_data_i} << shamt;
    assign ld_word     = WORD_WIDTH'({ld_hi_i, ld_lo_i} >> shamt);

    always_comb begin
        sign = 1'b0;
        unique case (size_i)
            LSU_SIZE_B: begin
                sign      = ~zero_ext_i & ld_word[7];
                ld_data_o = {{24{sign}}, ld_word[7:0]};
            end
            LSU_SIZE_H: begin
                sign      = ~zero_ext_i & ld_word[15];
                ld_data_o = {{16{sign}}, ld_word[15:0]};
            end
            default: ld_data_o = ld_word;
        endcase
    end

endmodule

// File: rtl/ram_lsu.sv
// Load/store initiator for the byte-lane data RAM; splits word-crossing accesses in two.
module ram_lsu
    import ram_lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RAM_ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH
) (
    input logic       clk,
    input logic       rst,
    ram_lsu_if.master bus
);

    typedef enum logic [2:0] {IDLE, ST_HI, LD_A, LD_B, LD_C} state_e;

    state_e                state_q, state_d;
    logic [LANES-1:0]      wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  zext_q, zext_d;
    logic                  split_q, split_d;
    logic [ADDR_WIDTH-1:0] hi_addr_q, hi_addr_d;
    logic [DATA_WIDTH-1:0] st_hi_q, st_hi_d;
    logic [LANES-1:0]      mask_hi_q, mask_hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;

    logic [ADDR_WIDTH-1:0] req_lo_addr, req_hi_addr;
    logic [2*LANES-1:0]    lane_mask;
    logic [DATA_WIDTH-1:0] st_lo, st_hi, ld_data;
    logic                  in_idle;

    assign in_idle     = (state_q == IDLE);
    assign req_lo_addr = {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};

    // The high word wraps inside the RAM-decoded field; upper bits pass through.
    always_comb begin
        req_hi_addr = req_lo_addr;
        req_hi_addr[RAM_ADDR_WIDTH-1:0] = req_lo_addr[RAM_ADDR_WIDTH-1:0] + RAM_ADDR_WIDTH'(4);
    end

    lsu_align u_align (
        .size_i      (in_idle ? bus.req_size_i : size_q),
        .zero_ext_i  (zext_q),
        .offset_i    (in_idle ? bus.req_addr_i[1:0] : off_q),
        .st_data_i   (bus.req_wdata_i),
        .ld_lo_i     (split_q ? lo_q : bus.ram_rd_data_i),
        .ld_hi_i     (bus.ram_rd_data_i),
        .lane_mask_o (lane_mask),
        .st_lo_o     (st_lo),
        .st_hi_o     (st_hi),
        .ld_data_o   (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        wr_en_d     = '0;
        rd_en_d     = 1'b0;
        rsp_valid_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        rsp_rdata_d = rsp_rdata_q;
        off_d       = off_q;
        size_d      = size_q;
        zext_d      = zext_q;
        split_d     = split_q;
        hi_addr_d   = hi_addr_q;
        st_hi_d     = st_hi_q;
        mask_hi_d   = mask_hi_q;
        lo_d        = lo_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    off_d     = bus.req_addr_i[1:0];
                    size_d    = bus.req_size_i;
                    zext_d    = bus.req_unsigned_i;
                    split_d   = |lane_mask[7:4];
                    hi_addr_d = req_hi_addr;
                    st_hi_d   = st_hi;
                    mask_hi_d = lane_mask[7:4];
                    if (bus.req_we_i) begin
                        wr_en_d   = lane_mask[3:0];
                        wr_addr_d = req_lo_addr;
                        wr_data_d = st_lo;
                        if (|lane_mask[7:4]) begin
                            state_d = ST_HI;
                        end else begin
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = '0;
                        end
                    end else begin
                        rd_en_d   = RD_ENABLE;
                        rd_addr_d = req_lo_addr;
                        state_d   = LD_A;
                    end
                end
            end
            ST_HI: begin
                wr_en_d     = mask_hi_q;
                wr_addr_d   = hi_addr_q;
                wr_data_d   = st_hi_q;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                state_d     = IDLE;
            end
            LD_A: begin
                if (split_q) begin
                    rd_en_d   = RD_ENABLE;
                    rd_addr_d = hi_addr_q;
                    state_d   = LD_B;
                end else begin
                    state_d = LD_C;
                end
            end
            LD_B: begin
                lo_d    = bus.ram_rd_data_i;
                state_d = LD_C;
            end
            LD_C: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ld_data;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            off_q       <= '0;
            size_q      <= '0;
            zext_q      <= 1'b0;
            split_q     <= 1'b0;
            hi_addr_q   <= '0;
            st_hi_q     <= '0;
            mask_hi_q   <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            off_q       <= off_d;
            size_q      <= size_d;
            zext_q      <= zext_d;
            split_q     <= split_d;
            hi_addr_q   <= hi_addr_d;
            st_hi_q     <= st_hi_d;
            mask_hi_q   <= mask_hi_d;
            lo_q        <= lo_d;
        end
    end

    assign bus.req_ready_o   = in_idle;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_rdata_o   = rsp_rdata_q;
    assign bus.ram_wr_en_o   = wr_en_q;
    assign bus.ram_wr_addr_o = wr_addr_q;
    assign bus.ram_wr_data_o = wr_data_q;
    assign bus.ram_rd_en_o   = rd_en_q;
    assign bus.ram_rd_addr_o = rd_addr_q;

endmodule

// File: tb/tb_ram_lsu.sv
// Directed bench for ram_lsu: vector table of whole transactions plus cycle-level sequences.
module tb_ram_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ram_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_ADDR_WIDTH(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Byte-lane RAM, 12 decoded address bits, one-cycle read latency
    logic [7:0] mem [4096];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.ram_wr_en_o[i])
                mem[{bus.ram_wr_addr_o[11:2], 2'(i)}] <= bus.ram_wr_data_o[8*i +: 8];
        end
        if (bus.ram_rd_en_o)
            bus.ram_rd_data_i <= {mem[{bus.ram_rd_addr_o[11:2], 2'd3}],
                                  mem[{bus.ram_rd_addr_o[11:2], 2'd2}],
                                  mem[{bus.ram_rd_addr_o[11:2], 2'd1}],
                                  mem[{bus.ram_rd_addr_o[11:2], 2'd0}]};
    end

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;

    always @(negedge clk) begin
        if (!rst && (|bus.ram_wr_en_o) && bus.ram_rd_en_o) overlap++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Returns positioned in C1 (1ns after the accept edge), request inputs scrambled.
    task automatic start_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        chk("req_ready before accept", 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = ~we;
        bus.req_size_i     = 2'b11;
        bus.req_unsigned_i = ~uns;
        bus.req_addr_i     = 32'hFFFF_FFFF;
        bus.req_wdata_i    = 32'h5A5A_5A5A;
    endtask

    task automatic wait_rsp(input int max, output int lat);
        lat = 1;
        while (!bus.rsp_valid_o && lat < max) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [23];

    initial begin
        int lat;
        int bad;

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        bus.ram_rd_data_i  = '0;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;

        //             we    size   uns   addr          wdata         lat rdata
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5, 1, 32'h0000_0000};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         3, 32'hFFFF_FFA5};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         3, 32'h0000_00A5};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         3, 32'hA5AD_BEEF};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         3, 32'hFFFF_BEEF};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,         3, 32'hFFFF_ADBE};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0007, 32'hFFFF_FF80, 1, 32'h0000_0000};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0008, 32'h0000_0090, 1, 32'h0000_0000};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0007, 32'h0,         4, 32'hFFFF_9080};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0007, 32'h0,         4, 32'h0000_9080};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h0000_7F01, 1, 32'h0000_0000};
        vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0,         3, 32'h0000_7F01};
        vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h0000_002F, 32'h0000_BBAA, 2, 32'h0000_0000};
        vecs[13] = '{1'b0, 2'b01, 1'b1, 32'h0000_002F, 32'h0,         4, 32'h0000_BBAA};
        vecs[14] = '{1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 1, 32'h0000_0000};
        vecs[15] = '{1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,         3, 32'hCAFE_F00D};
        vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h0000_0023, 32'h0,         4, 32'h0011_2233};
        vecs[17] = '{1'b0, 2'b01, 1'b0, 32'h0000_0023, 32'h0,         4, 32'h0000_2233};
        vecs[18] = '{1'b0, 2'b10, 1'b0, 32'h0000_0021, 32'h0,         4, 32'h2233_4400};
        vecs[19] = '{1'b0, 2'b00, 1'b0, 32'h0000_0022, 32'h0,         3, 32'h0000_0044};
        vecs[20] = '{1'b1, 2'b10, 1'b0, 32'h0000_0FFE, 32'h0102_0304, 2, 32'h0000_0000};
        vecs[21] = '{1'b0, 2'b10, 1'b0, 32'h0000_0FFE, 32'h0,         4, 32'h0102_0304};
        vecs[22] = '{1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,         3, 32'h0000_0001};

        // Reset state
        #12;
        chk("reset req_ready", 32'(bus.req_ready_o), 32'd1);
        chk("reset rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("reset rsp_rdata", bus.rsp_rdata_o, 32'd0);
        chk("reset wr_en", 32'(bus.ram_wr_en_o), 32'd0);
        chk("reset rd_en", 32'(bus.ram_rd_en_o), 32'd0);
        chk("reset wr_addr", bus.ram_wr_addr_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Aligned word store
        start_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        chk("st_w C1 wr_en", 32'(bus.ram_wr_en_o), 32'hF);
        chk("st_w C1 wr_addr", bus.ram_wr_addr_o, 32'h10);
        chk("st_w C1 wr_data", bus.ram_wr_data_o, 32'hDEAD_BEEF);
        chk("st_w C1 rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        chk("st_w C1 req_ready", 32'(bus.req_ready_o), 32'd1);
        chk("st_w C1 rd_en", 32'(bus.ram_rd_en_o), 32'd0);

        // Split word store at offset 2
        start_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h1122_3344);
        chk("st_split C1 wr_en", 32'(bus.ram_wr_en_o), 32'hC);
        chk("st_split C1 wr_addr", bus.ram_wr_addr_o, 32'h20);
        chk("st_split C1 lanes 3:2", 32'(bus.ram_wr_data_o[31:16]), 32'h3344);
        chk("st_split C1 rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        @(posedge clk); #1;
        chk("st_split C2 wr_en", 32'(bus.ram_wr_en_o), 32'h3);
        chk("st_split C2 wr_addr", bus.ram_wr_addr_o, 32'h24);
        chk("st_split C2 lanes 1:0", 32'(bus.ram_wr_data_o[15:0]), 32'h1122);
        chk("st_split C2 rsp_valid", 32'(bus.rsp_valid_o), 32'd1);

        // Split word load at offset 2
        start_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
        chk("ld_split C1 rd_en", 32'(bus.ram_rd_en_o), 32'd1);
        chk("ld_split C1 rd_addr", bus.ram_rd_addr_o, 32'h20);
        @(posedge clk); #1;
        chk("ld_split C2 rd_en", 32'(bus.ram_rd_en_o), 32'd1);
        chk("ld_split C2 rd_addr", bus.ram_rd_addr_o, 32'h24);
        @(posedge clk); #1;
        chk("ld_split C3 rd_en", 32'(bus.ram_rd_en_o), 32'd0);
        chk("ld_split C3 rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        @(posedge clk); #1;
        chk("ld_split C4 rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        chk("ld_split C4 rsp_rdata", bus.rsp_rdata_o, 32'h1122_3344);

        // Vector table, each new request issued in the previous response cycle
        for (int i = 0; i < 23; i++) begin
            start_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            wait_rsp(8, lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d rsp_rdata", i), bus.rsp_rdata_o, vecs[i].rdata);
        end

        // Wrap of the high word inside the decoded field, upper bits preserved
        start_req(1'b0, 2'b10, 1'b0, 32'h0000_5FFE, 32'h0);
        chk("wrap C1 rd_addr", bus.ram_rd_addr_o, 32'h0000_5FFC);
        @(posedge clk); #1;
        chk("wrap C2 rd_addr", bus.ram_rd_addr_o, 32'h0000_5000);
        wait_rsp(8, lat);
        chk("wrap latency", 32'(lat), 32'd3);
        chk("wrap rsp_rdata", bus.rsp_rdata_o, 32'h0102_0304);

        // Reset during C2 of a split load drops the transaction
        start_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid-rst rd_en", 32'(bus.ram_rd_en_o), 32'd0);
        chk("mid-rst rd_addr", bus.ram_rd_addr_o, 32'd0);
        chk("mid-rst wr_en", 32'(bus.ram_wr_en_o), 32'd0);
        chk("mid-rst rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("mid-rst rsp_rdata", bus.rsp_rdata_o, 32'd0);
        chk("mid-rst req_ready", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid_o || bus.ram_rd_en_o || (|bus.ram_wr_en_o)) bad++;
        end
        chk("post-rst idle strobes", 32'(bad), 32'd0);

        start_req(1'b1, 2'b10, 1'b0, 32'h50, 32'h5555_AAAA);
        wait_rsp(8, lat);
        chk("post-rst store latency", 32'(lat), 32'd1);
        start_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
        wait_rsp(8, lat);
        chk("post-rst load latency", 32'(lat), 32'd3);
        chk("post-rst load rdata", bus.rsp_rdata_o, 32'h5555_AAAA);
        @(posedge clk); #1;
        chk("rsp pulse one cycle", 32'(bus.rsp_valid_o), 32'd0);
        chk("rsp_rdata holds", bus.rsp_rdata_o, 32'h5555_AAAA);

        chk("no write with read", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no summary, expected completion");
        $fatal(1, "timeout");
    end

endmodule
